// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM arbiter: FSM encoding, LSB size
// codes, grant identities and the RAM data/address widths.
package mem_arbiter_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_IF_RD = 2'd1;
   localparam logic [1:0] ST_LS_RD = 2'd2;
   localparam logic [1:0] ST_LS_WR = 2'd3;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_RSVD = 2'd3;

   localparam logic GRANT_IF  = 1'b0;
   localparam logic GRANT_LSB = 1'b1;

   localparam logic [2:0] FETCH_LEN = 3'd4;

   // Number of bytes moved for an LSB access; the reserved code behaves as a word.
   function automatic logic [2:0] accessLen(input logic [1:0] size);
      logic [2:0] len;
      case (size)
         SIZE_BYTE: len = 3'd1;
         SIZE_HALF: len = 3'd2;
         SIZE_WORD: len = 3'd4;
         SIZE_RSVD: len = 3'd4;
         default:   len = 3'd4;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide synchronous RAM between instruction fetch and
// the load/store buffer. Words are moved one byte per cycle, little-endian.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [WORD_W-1:0] if_data,
   input  logic              lsb_req,
   input  logic              lsb_wr,
   input  logic [1:0]        lsb_size,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [WORD_W-1:0] lsb_wdata,
   output logic              lsb_done,
   output logic [WORD_W-1:0] lsb_rdata,
   input  logic [DATA_W-1:0] mem_din,
   output logic [DATA_W-1:0] mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);

   logic [1:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic              lastGrant_q, lastGrant_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [WORD_W-1:0] ifData_q, ifData_d;
   logic [WORD_W-1:0] lsbRdata_q, lsbRdata_d;
   logic              ifDone_q, ifDone_d;
   logic              lsbDone_q, lsbDone_d;
   logic [ADDR_W-1:0] memA_q, memA_d;
   logic [DATA_W-1:0] memDout_q, memDout_d;
   logic [WORD_W-1:0] rdBuf_q, rdWord;
   logic              prevRdy_q;
   logic              capture;
   logic              ifElig, lsbElig, pickLsb;

   // A returned byte is fresh only if the previous cycle advanced the address;
   // grabbing it even while frozen keeps the RAM pipeline aligned after a stall.
   always_comb begin
      capture = ((state_q == ST_IF_RD) || (state_q == ST_LS_RD)) &&
                (cnt_q != 3'd0) && prevRdy_q;
      rdWord  = rdBuf_q;
      if (capture) begin
         case (cnt_q)
            3'd1:    rdWord[7:0]   = mem_din;
            3'd2:    rdWord[15:8]  = mem_din;
            3'd3:    rdWord[23:16] = mem_din;
            default: rdWord[31:24] = mem_din;
         endcase
      end
   end

   // Arbitration and byte sequencing; done flags block re-granting the same
   // requester in the cycle it is being told it finished.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      lastGrant_d = lastGrant_q;
      wdata_d     = wdata_q;
      ifData_d    = ifData_q;
      lsbRdata_d  = lsbRdata_q;
      ifDone_d    = 1'b0;
      lsbDone_d   = 1'b0;
      memA_d      = memA_q;
      memDout_d   = memDout_q;
      ifElig      = if_req & ~ifDone_q;
      lsbElig     = lsb_req & ~lsbDone_q;
      pickLsb     = lsbElig & (~ifElig | (lastGrant_q == GRANT_IF));
      case (state_q)
         ST_IDLE: begin
            if (!clr) begin
               if (pickLsb) begin
                  state_d     = lsb_wr ? ST_LS_WR : ST_LS_RD;
                  lastGrant_d = GRANT_LSB;
                  len_d       = accessLen(lsb_size);
                  memA_d      = lsb_addr;
                  memDout_d   = lsb_wdata[7:0];
                  wdata_d     = lsb_wdata;
                  cnt_d       = 3'd0;
               end else if (ifElig) begin
                  state_d     = ST_IF_RD;
                  lastGrant_d = GRANT_IF;
                  len_d       = FETCH_LEN;
                  memA_d      = if_addr;
                  cnt_d       = 3'd0;
               end
            end
         end
         ST_IF_RD, ST_LS_RD: begin
            if (clr) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == len_q) begin
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
               if (state_q == ST_IF_RD) begin
                  ifData_d = rdWord;
                  ifDone_d = 1'b1;
               end else begin
                  case (len_q)
                     3'd1:    lsbRdata_d = {24'd0, rdWord[7:0]};
                     3'd2:    lsbRdata_d = {16'd0, rdWord[15:0]};
                     default: lsbRdata_d = rdWord;
                  endcase
                  lsbDone_d = 1'b1;
               end
            end else begin
               if (cnt_q < (len_q - 3'd1)) begin
                  memA_d = memA_q + 32'd1;
               end
               cnt_d = cnt_q + 3'd1;
            end
         end
         ST_LS_WR: begin
            if (cnt_q == (len_q - 3'd1)) begin
               state_d   = ST_IDLE;
               cnt_d     = 3'd0;
               lsbDone_d = 1'b1;
            end else begin
               cnt_d  = cnt_q + 3'd1;
               memA_d = memA_q + 32'd1;
               case (cnt_q)
                  3'd0:    memDout_d = wdata_q[15:8];
                  3'd1:    memDout_d = wdata_q[23:16];
                  default: memDout_d = wdata_q[31:24];
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Architectural state only advances while rdy is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         len_q       <= 3'd0;
         lastGrant_q <= GRANT_IF;
         wdata_q     <= '0;
         ifData_q    <= '0;
         lsbRdata_q  <= '0;
         ifDone_q    <= 1'b0;
         lsbDone_q   <= 1'b0;
         memA_q      <= '0;
         memDout_q   <= '0;
      end else if (rdy) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         lastGrant_q <= lastGrant_d;
         wdata_q     <= wdata_d;
         ifData_q    <= ifData_d;
         lsbRdata_q  <= lsbRdata_d;
         ifDone_q    <= ifDone_d;
         lsbDone_q   <= lsbDone_d;
         memA_q      <= memA_d;
         memDout_q   <= memDout_d;
      end
   end

   // Read assembly buffer and rdy history run every cycle to track RAM latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdBuf_q   <= '0;
         prevRdy_q <= 1'b0;
      end else begin
         rdBuf_q   <= rdWord;
         prevRdy_q <= rdy;
      end
   end

   assign if_done   = ifDone_q & rdy;
   assign lsb_done  = lsbDone_q & rdy;
   assign if_data   = ifData_q;
   assign lsb_rdata = lsbRdata_q;
   assign mem_a     = memA_q;
   assign mem_dout  = memDout_q;
   assign mem_wr    = (state_q == ST_LS_WR) & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide RAM model.
// Stimulus is applied and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, clr;
   logic        if_req, if_done;
   logic [31:0] if_addr, if_data;
   logic        lsb_req, lsb_wr, lsb_done;
   logic [1:0]  lsb_size;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   int errors = 0;
   int checks = 0;

   logic [7:0] ram [0:65535];

   // Free-running clock
   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .clr       (clr),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_data   (if_data),
      .lsb_req   (lsb_req),
      .lsb_wr    (lsb_wr),
      .lsb_size  (lsb_size),
      .lsb_addr  (lsb_addr),
      .lsb_wdata (lsb_wdata),
      .lsb_done  (lsb_done),
      .lsb_rdata (lsb_rdata),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .mem_a     (mem_a),
      .mem_wr    (mem_wr)
   );

   // Synchronous RAM: returns the byte addressed last cycle, writes on strobe
   always @(posedge clk) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] = mem_dout;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                input logic lsbReq, input logic lsbWr,
                                input logic [1:0] lsbSize, input logic [31:0] lsbAddr,
                                input logic [31:0] lsbWdata);
      if_req    = ifReq;
      if_addr   = ifAddr;
      lsb_req   = lsbReq;
      lsb_wr    = lsbWr;
      lsb_size  = lsbSize;
      lsb_addr  = lsbAddr;
      lsb_wdata = lsbWdata;
   endtask

   task automatic doReset();
      rst = 1'b1;
      rdy = 1'b1;
      clr = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0010] = 8'h80;
      ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22;
      ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
      ram[16'h2002] = 8'h5A;
      ram[16'h0400] = 8'h01; ram[16'h0401] = 8'h02;
      ram[16'h0402] = 8'h03; ram[16'h0403] = 8'h04;
      for (int i = 16'h0500; i < 16'h0504; i++) ram[i] = 8'hEE;

      doReset();
      checkOutput("reset if_done",   32'(if_done),   32'h0);
      checkOutput("reset lsb_done",  32'(lsb_done),  32'h0);
      checkOutput("reset if_data",   if_data,        32'h0);
      checkOutput("reset lsb_rdata", lsb_rdata,      32'h0);
      checkOutput("reset mem_a",     mem_a,          32'h0);
      checkOutput("reset mem_wr",    32'(mem_wr),    32'h0);
      checkOutput("reset mem_dout",  32'(mem_dout),  32'h0);

      // Lone word fetch
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         nextCycle();
         checkOutput($sformatf("fetch mem_a c%0d", c), mem_a, 32'h100 + 32'(c) - 32'd1);
         checkOutput($sformatf("fetch mem_wr c%0d", c), 32'(mem_wr), 32'h0);
      end
      nextCycle();
      checkOutput("fetch early done", 32'(if_done), 32'h0);
      nextCycle();
      checkOutput("fetch done", 32'(if_done), 32'h1);
      checkOutput("fetch data", if_data, 32'h44332211);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("fetch done width", 32'(if_done), 32'h0);
      checkOutput("fetch data hold", if_data, 32'h44332211);

      // Half-word store
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'd1, 32'h2000, 32'hAABBCCDD);
      nextCycle();
      checkOutput("st16 wr c1",   32'(mem_wr),   32'h1);
      checkOutput("st16 a c1",    mem_a,         32'h2000);
      checkOutput("st16 dout c1", 32'(mem_dout), 32'hDD);
      nextCycle();
      checkOutput("st16 wr c2",   32'(mem_wr),   32'h1);
      checkOutput("st16 a c2",    mem_a,         32'h2001);
      checkOutput("st16 dout c2", 32'(mem_dout), 32'hCC);
      checkOutput("st16 early done", 32'(lsb_done), 32'h0);
      nextCycle();
      checkOutput("st16 done",  32'(lsb_done), 32'h1);
      checkOutput("st16 wr c3", 32'(mem_wr),   32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("st16 ram 2000", 32'(ram[16'h2000]), 32'hDD);
      checkOutput("st16 ram 2001", 32'(ram[16'h2001]), 32'hCC);
      checkOutput("st16 ram 2002", 32'(ram[16'h2002]), 32'h5A);

      // Simultaneous requests from reset: LSB first, then fetch, then LSB again
      doReset();
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0);
      nextCycle();
      checkOutput("tie1 mem_a", mem_a, 32'h10);
      nextCycle();
      nextCycle();
      checkOutput("tie1 lsb_done",  32'(lsb_done), 32'h1);
      checkOutput("tie1 lsb_rdata", lsb_rdata,     32'h00000080);
      checkOutput("tie1 if_done",   32'(if_done),  32'h0);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0);
      nextCycle();
      checkOutput("tie1 fetch grant", mem_a, 32'h100);
      repeat (5) nextCycle();
      checkOutput("tie1 if_done", 32'(if_done), 32'h1);
      checkOutput("tie1 if_data", if_data, 32'h44332211);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0);
      nextCycle();
      checkOutput("tie2 goes to lsb", mem_a, 32'h10);
      doReset();

      // Fetch aborted by clr in cycle 3
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      nextCycle();
      nextCycle();
      clr = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      clr = 1'b0;
      checkOutput("abort mem_a", mem_a, 32'h102);
      for (int c = 4; c <= 8; c++) begin
         checkOutput($sformatf("abort no done c%0d", c), 32'(if_done), 32'h0);
         nextCycle();
      end
      checkOutput("abort if_data", if_data, 32'h0);

      // Word store not aborted by clr in cycle 2
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h3000, 32'h12345678);
      nextCycle();
      checkOutput("st32 a c1",    mem_a,         32'h3000);
      checkOutput("st32 dout c1", 32'(mem_dout), 32'h78);
      nextCycle();
      clr = 1'b1;
      checkOutput("st32 a c2", mem_a, 32'h3001);
      nextCycle();
      clr = 1'b0;
      checkOutput("st32 wr c3",   32'(mem_wr),   32'h1);
      checkOutput("st32 a c3",    mem_a,         32'h3002);
      checkOutput("st32 dout c3", 32'(mem_dout), 32'h34);
      nextCycle();
      checkOutput("st32 dout c4", 32'(mem_dout), 32'h12);
      nextCycle();
      checkOutput("st32 done", 32'(lsb_done), 32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();
      checkOutput("st32 ram", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'h12345678);

      // Word load with rdy low in cycles 2-4
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h400, 32'h0);
      nextCycle();
      checkOutput("stall a c1", mem_a, 32'h400);
      for (int c = 2; c <= 9; c++) begin
         nextCycle();
         if (c == 2) rdy = 1'b0;
         if (c == 5) rdy = 1'b1;
         if (c <= 4) begin
            checkOutput($sformatf("stall a c%0d", c), mem_a, 32'h401);
            checkOutput($sformatf("stall wr c%0d", c), 32'(mem_wr), 32'h0);
         end
         checkOutput($sformatf("stall done c%0d", c), 32'(lsb_done), (c == 9) ? 32'h1 : 32'h0);
      end
      checkOutput("stall rdata", lsb_rdata, 32'h04030201);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();

      // Reserved size code behaves as a word load
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
      repeat (6) nextCycle();
      checkOutput("rsvd done",  32'(lsb_done), 32'h1);
      checkOutput("rsvd rdata", lsb_rdata,     32'h44332211);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();

      // Reset during byte 2 of a word store
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'd2, 32'h500, 32'hCAFEF00D);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("rststore a c3",    mem_a,         32'h502);
      checkOutput("rststore dout c3", 32'(mem_dout), 32'hFE);
      rst = 1'b1;
      #1;
      checkOutput("rststore wr",   32'(mem_wr),   32'h0);
      checkOutput("rststore a",    mem_a,         32'h0);
      checkOutput("rststore dout", 32'(mem_dout), 32'h0);
      checkOutput("rststore rdata", lsb_rdata,    32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         checkOutput($sformatf("rststore no done %0d", c), 32'(lsb_done), 32'h0);
      end
      checkOutput("rststore ram", {ram[16'h0503], ram[16'h0502], ram[16'h0501], ram[16'h0500]}, 32'hEEEEF00D);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 32'h10, 32'h0);
      repeat (3) nextCycle();
      checkOutput("post-reset done",  32'(lsb_done), 32'h1);
      checkOutput("post-reset rdata", lsb_rdata,     32'h00000080);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      nextCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
